// File: rtl/redundancy_compressor.sv
// redundancy_compressor
// Streams lowered-IFM rows through a column-serial scan that drops words
// already emitted earlier in the group. For each row it produces a packed
// dense word vector and a group-global mapping table.
module redundancy_compressor #(
    parameter int WORD_WIDTH = 8,
    parameter int DIST_WIDTH = 7,
    parameter int STEP_RANGE = 128,
    parameter int MAX_ROWS   = 4,
    parameter int MAP_WIDTH  = 9,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [STEP_RANGE*WORD_WIDTH-1:0] in_row,
    input  logic [DIST_WIDTH-1:0]            in_dist,
    input  logic                             in_dist_vld,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [STEP_RANGE*WORD_WIDTH-1:0] out_dense,
    output logic [CNT_WIDTH-1:0]             out_cnt,
    output logic [STEP_RANGE*MAP_WIDTH-1:0]  out_map,
    output logic                             out_last
);

    localparam int COL_W = (STEP_RANGE > 1) ? $clog2(STEP_RANGE) : 1;
    localparam int RI_W  = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
    // The shifted column index must hold col + d without wrapping.
    localparam int SUM_W = ((DIST_WIDTH > COL_W) ? DIST_WIDTH : COL_W) + 1;

    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(STEP_RANGE - 1);
    localparam logic [SUM_W-1:0] SUM_LIMIT = SUM_W'(STEP_RANGE);
    localparam logic [RI_W-1:0]  LAST_ROW  = RI_W'(MAX_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic [WORD_WIDTH-1:0] row_words [STEP_RANGE];
    logic [WORD_WIDTH-1:0] dense     [STEP_RANGE];
    logic [MAP_WIDTH-1:0]  cur_map   [STEP_RANGE];
    logic [MAP_WIDTH-1:0]  prev_map  [STEP_RANGE];

    logic [DIST_WIDTH-1:0] dist_reg;
    logic                  dist_vld_reg;
    logic                  last_reg;
    logic [COL_W-1:0]      col;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [RI_W-1:0]       row_idx;
    logic [MAP_WIDTH-1:0]  dense_base;

    logic [SUM_W-1:0]      col_sum;
    logic                  redundant;
    logic [COL_W-1:0]      prev_sel;
    logic [MAP_WIDTH-1:0]  unique_idx;
    logic                  closing;

    // State register for the accept / scan / present sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one row in flight at a time.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = SCAN;
            SCAN: if (col == LAST_COL) state_next = OUT;
            OUT:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-column redundancy decision and the index a unique word would get.
    always_comb begin
        col_sum    = SUM_W'(dist_reg) + SUM_W'(col);
        redundant  = (row_idx != '0) && dist_vld_reg && (col_sum < SUM_LIMIT);
        prev_sel   = col_sum[COL_W-1:0];
        unique_idx = dense_base + MAP_WIDTH'(cnt);
        closing    = last_reg || (row_idx == LAST_ROW);
    end

    // Row latch, column scan, and group bookkeeping on the output handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            dist_reg     <= '0;
            dist_vld_reg <= 1'b0;
            last_reg     <= 1'b0;
            col          <= '0;
            cnt          <= '0;
            row_idx      <= '0;
            dense_base   <= '0;
            for (int i = 0; i < STEP_RANGE; i++) begin
                row_words[i] <= '0;
                dense[i]     <= '0;
                cur_map[i]   <= '0;
                prev_map[i]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dist_reg     <= in_dist;
                        dist_vld_reg <= in_dist_vld;
                        last_reg     <= in_last;
                        col          <= '0;
                        cnt          <= '0;
                        for (int i = 0; i < STEP_RANGE; i++) begin
                            row_words[i] <= in_row[i*WORD_WIDTH +: WORD_WIDTH];
                            dense[i]     <= '0;
                        end
                    end
                end
                SCAN: begin
                    if (redundant) begin
                        cur_map[col] <= prev_map[prev_sel];
                    end else begin
                        cur_map[col]                <= unique_idx;
                        dense[cnt[COL_W-1:0]]       <= row_words[col];
                        cnt                         <= cnt + CNT_WIDTH'(1);
                    end
                    col <= col + COL_W'(1);
                end
                OUT: begin
                    if (out_ready) begin
                        for (int i = 0; i < STEP_RANGE; i++) begin
                            prev_map[i] <= cur_map[i];
                        end
                        if (closing) begin
                            row_idx    <= '0;
                            dense_base <= '0;
                        end else begin
                            row_idx    <= row_idx + RI_W'(1);
                            dense_base <= dense_base + MAP_WIDTH'(cnt);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign out_cnt   = cnt;
    assign out_last  = closing;

    for (genvar g = 0; g < STEP_RANGE; g++) begin : g_pack
        assign out_dense[g*WORD_WIDTH +: WORD_WIDTH] = dense[g];
        assign out_map[g*MAP_WIDTH +: MAP_WIDTH]     = cur_map[g];
    end

endmodule

// File: tb/tb_redundancy_compressor.sv
// Testbench for redundancy_compressor with an 8-column window.
// Expected rows are queued when a row is sent and checked when it emerges.
module tb_redundancy_compressor;

    localparam int WW = 8;
    localparam int DW = 7;
    localparam int SR = 8;
    localparam int MR = 4;
    localparam int MW = 5;
    localparam int CW = 8;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [SR*WW-1:0]   in_row;
    logic [DW-1:0]      in_dist;
    logic               in_dist_vld;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [SR*WW-1:0]   out_dense;
    logic [CW-1:0]      out_cnt;
    logic [SR*MW-1:0]   out_map;
    logic               out_last;

    typedef struct {
        logic [SR*WW-1:0] dense;
        logic [CW-1:0]    cnt;
        logic [SR*MW-1:0] map;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    redundancy_compressor #(
        .WORD_WIDTH(WW),
        .DIST_WIDTH(DW),
        .STEP_RANGE(SR),
        .MAX_ROWS  (MR),
        .MAP_WIDTH (MW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row     (in_row),
        .in_dist    (in_dist),
        .in_dist_vld(in_dist_vld),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dense  (out_dense),
        .out_cnt    (out_cnt),
        .out_map    (out_map),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue an expected row: lanes 0..n-1 carry the listed words, rest are 0.
    task automatic push_exp(input int words[SR], input int n, input int maps[SR], input bit last);
        exp_t e;
        e.dense = '0;
        e.map   = '0;
        for (int i = 0; i < SR; i++) begin
            if (i < n) e.dense[i*WW +: WW] = words[i][WW-1:0];
            e.map[i*MW +: MW] = maps[i][MW-1:0];
        end
        e.cnt  = CW'(n);
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Present one row and hold it until accepted; scramble inputs afterwards.
    task automatic send_row(input int words[SR], input int d, input bit dvld, input bit last);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout in_ready=%b required=1", in_ready);
            return;
        end
        for (int i = 0; i < SR; i++) in_row[i*WW +: WW] = words[i][WW-1:0];
        in_dist     = DW'(d);
        in_dist_vld = dvld;
        in_last     = last;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
        in_row      = {$urandom, $urandom};
        in_dist     = DW'($urandom);
        in_dist_vld = 1'($urandom);
        in_last     = 1'($urandom);
    endtask

    // Wait for an output row, compare it against the scoreboard, accept it.
    task automatic recv_row(output int lat);
        exp_t e;
        int   n;
        bit   seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        lat = n;
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL recv_timeout out_valid=%b required=1", out_valid);
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_row queue empty, cnt=%0d", out_cnt);
        end else begin
            e = exp_q.pop_front();
            if (out_dense !== e.dense) begin
                errors++;
                $display("[TB] FAIL out_dense got=%h required=%h", out_dense, e.dense);
            end
            checks++;
            if (out_cnt !== e.cnt) begin
                errors++;
                $display("[TB] FAIL out_cnt got=%0d required=%0d", out_cnt, e.cnt);
            end
            checks++;
            if (out_map !== e.map) begin
                errors++;
                $display("[TB] FAIL out_map got=%h required=%h", out_map, e.map);
            end
            checks++;
            if (out_last !== e.last) begin
                errors++;
                $display("[TB] FAIL out_last got=%b required=%b", out_last, e.last);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_handshake in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_row      = '0;
        in_dist     = '0;
        in_dist_vld = 1'b0;
        in_last     = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_cnt !== '0 ||
            out_dense !== '0 || out_map !== '0 || out_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state valid=%b ready=%b cnt=%0d dense=%h map=%h last=%b required 0/1/0/0/0/0",
                     out_valid, in_ready, out_cnt, out_dense, out_map, out_last);
        end
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL idle_out_ready valid=%b ready=%b required 0/1", out_valid, in_ready);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_single_row();
        int w[SR];
        int m[SR];
        int lat;
        do_reset();
        for (int i = 0; i < SR; i++) begin
            w[i] = i + 1;
            m[i] = i;
        end
        push_exp(w, 8, m, 1'b1);
        send_row(w, 3, 1'b1, 1'b1);
        recv_row(lat);
        checks++;
        if (lat != SR) begin
            errors++;
            $display("[TB] FAIL latency got=%0d required=%0d", lat, SR);
        end
    endtask

    task automatic test_chain();
        int w[SR];
        int m[SR];
        int e[SR];
        int lat;
        do_reset();
        for (int i = 0; i < SR; i++) begin
            w[i] = i + 1;
            m[i] = i;
        end
        push_exp(w, 8, m, 1'b0);
        send_row(w, 2, 1'b1, 1'b0);
        recv_row(lat);
        for (int i = 0; i < SR; i++) begin
            w[i] = i + 3;
            m[i] = i + 2;
            e[i] = 0;
        end
        e[0] = 9;
        e[1] = 10;
        push_exp(e, 2, m, 1'b0);
        send_row(w, 2, 1'b1, 1'b0);
        recv_row(lat);
        for (int i = 0; i < SR; i++) begin
            w[i] = i + 5;
            m[i] = i + 4;
        end
        e[0] = 11;
        e[1] = 12;
        push_exp(e, 2, m, 1'b1);
        send_row(w, 2, 1'b1, 1'b1);
        recv_row(lat);
    endtask

    task automatic test_zero_dist();
        int w[SR];
        int m[SR];
        int lat;
        do_reset();
        for (int i = 0; i < SR; i++) begin
            w[i] = 40 + i;
            m[i] = i;
        end
        push_exp(w, 8, m, 1'b0);
        send_row(w, 0, 1'b1, 1'b0);
        recv_row(lat);
        for (int i = 0; i < SR; i++) w[i] = 90 + i;
        push_exp(w, 0, m, 1'b1);
        send_row(w, 0, 1'b1, 1'b1);
        recv_row(lat);
    endtask

    task automatic test_exception();
        int w[SR];
        int m[SR];
        int lat;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            for (int i = 0; i < SR; i++) begin
                w[i] = i + 1;
                m[i] = i;
            end
            push_exp(w, 8, m, 1'b0);
            send_row(w, 2, 1'b1, 1'b0);
            recv_row(lat);
            for (int i = 0; i < SR; i++) begin
                w[i] = i + 3;
                m[i] = i + 8;
            end
            push_exp(w, 8, m, 1'b1);
            if (k == 0) send_row(w, 2, 1'b0, 1'b1);
            else        send_row(w, 9, 1'b1, 1'b1);
            recv_row(lat);
        end
    endtask

    task automatic test_forced_close();
        int w[SR];
        int m[SR];
        int lat;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < SR; i++) begin
                w[i] = r * 16 + i + 1;
                m[i] = r * 8 + i;
            end
            push_exp(w, 8, m, (r == 3));
            send_row(w, 1, 1'b0, 1'b0);
            recv_row(lat);
        end
        for (int i = 0; i < SR; i++) begin
            w[i] = 200 + i;
            m[i] = i;
        end
        push_exp(w, 8, m, 1'b0);
        send_row(w, 0, 1'b1, 1'b0);
        recv_row(lat);
    endtask

    task automatic test_backpressure();
        int   w[SR];
        int   m[SR];
        int   n;
        exp_t e;
        do_reset();
        for (int i = 0; i < SR; i++) begin
            w[i] = 8 - i;
            m[i] = i;
        end
        push_exp(w, 8, m, 1'b1);
        send_row(w, 0, 1'b0, 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_timeout out_valid=%b required=1", out_valid);
            return;
        end
        e = exp_q.pop_front();
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_dense !== e.dense ||
                out_cnt !== e.cnt || out_map !== e.map || out_last !== e.last) begin
                errors++;
                $display("[TB] FAIL bp_hold valid=%b ready=%b cnt=%0d dense=%h map=%h required 1/0/%0d/%h/%h",
                         out_valid, in_ready, out_cnt, out_dense, out_map, e.cnt, e.dense, e.map);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release valid=%b ready=%b required 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_single_handshake valid=%b required=0", out_valid);
        end
    endtask

    task automatic test_mid_scan_reset();
        int w[SR];
        int m[SR];
        int lat;
        bit bad;
        do_reset();
        for (int i = 0; i < SR; i++) begin
            w[i] = 20 + i;
            m[i] = i;
        end
        push_exp(w, 8, m, 1'b0);
        send_row(w, 2, 1'b1, 1'b0);
        recv_row(lat);
        for (int i = 0; i < SR; i++) w[i] = 50 + i;
        send_row(w, 2, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL abort_no_output out_valid seen=1 required=0");
        end
        for (int i = 0; i < SR; i++) begin
            w[i] = 22 + i;
            m[i] = i;
        end
        push_exp(w, 8, m, 1'b1);
        send_row(w, 2, 1'b1, 1'b1);
        recv_row(lat);
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_single_row();
        test_chain();
        test_zero_dist();
        test_exception();
        test_forced_close();
        test_backpressure();
        test_mid_scan_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_leftover size=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/redundancy_compressor.md
# redundancy_compressor

Streaming successor to the LIFM redundancy controller. It accepts one lowered-IFM row (one kernel element, STEP_RANGE columns) per handshake, together with that row's pixel distance to the previous row. It removes elements that duplicate an element already emitted, and emits per row a packed dense word vector plus a group-global mapping table. It sits between the distance-calculation stage and the dense PE-array feeder. Row count per group, column window and index widths are parameters, and redundancy is resolved transitively across any number of rows.

## Interface
- WORD_WIDTH, 8, activation word bitwidth
- DIST_WIDTH, 7, distance bitwidth
- STEP_RANGE, 128, columns per row (LIFM column window)
- MAX_ROWS, 4, maximum rows per group (≥2)
- MAP_WIDTH, 9, mapping index width; must satisfy 2^MAP_WIDTH ≥ MAX_ROWS*STEP_RANGE
- CNT_WIDTH, 8, dense count width; must satisfy 2^CNT_WIDTH > STEP_RANGE
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input row valid
- in_ready  out  1  block can accept a row
- in_row  in  STEP_RANGE*WORD_WIDTH  row data; lane c = column c
- in_dist  in  DIST_WIDTH  distance d to the previous row of the group
- in_dist_vld  in  1  1 = d is meaningful; 0 = no redundancy (distance exception)
- in_last  in  1  row closes the group
- out_valid  out  1  output row valid
- out_ready  in  1  consumer accepts the output row
- out_dense  out  STEP_RANGE*WORD_WIDTH  unique words packed into lanes 0..out_cnt-1; upper lanes 0
- out_cnt  out  CNT_WIDTH  number of unique words in this row
- out_map  out  STEP_RANGE*MAP_WIDTH  per-column group-global dense index
- out_last  out  1  row closes the group

## Operation
- FSM states: IDLE, SCAN, OUT. in_ready = (state==IDLE).
- IDLE: on in_valid&&in_ready, latch in_row, d, dist_vld and last. Zero the packed lanes and the column counter col. Move to SCAN.
- SCAN: process one column per cycle, col = 0..STEP_RANGE-1.
  - Column c is redundant iff row_idx>0 && dist_vld && c+d < STEP_RANGE. The sum is computed at DIST_WIDTH+1 bits, so no wrap.
  - Redundant column: cur_map[c] = prev_map[c+d].
  - Unique column: cur_map[c] = dense_base + cnt; lane cnt = word c; cnt++.
  - After c = STEP_RANGE-1, move to OUT.
- OUT: hold out_valid=1 with all outputs stable until out_ready is sampled high.
  - On that handshake: prev_map ← cur_map; dense_base += cnt.
  - If closing (latched last, or row_idx == MAX_ROWS-1): set row_idx=0 and dense_base=0. Otherwise row_idx++.
  - Return to IDLE.
- out_last = latched last || row_idx == MAX_ROWS-1. A group is forcibly closed at MAX_ROWS rows, with no error.
- Row 0 of a group is always fully unique, regardless of in_dist_vld.
- d=0 with dist_vld makes every column redundant, mapping to the same column of the previous row.
- Mapping is transitive: a chain of redundant rows always resolves to the index of the originally emitted word.
- in_row, in_dist, in_dist_vld and in_last are ignored outside an IDLE handshake.

## Timing
- Reset (synchronous, checked at clk edge): state=IDLE, row_idx=0, dense_base=0, prev_map=0, all out_* = 0, out_valid=0. in_ready=1 from the first cycle after reset.
- Reset asserted in any state aborts the row and the group. Partial results are discarded and nothing is emitted.
- Input accepted at edge T. SCAN spans edges T+1..T+STEP_RANGE. out_valid rises after edge T+STEP_RANGE. Latency is STEP_RANGE+1 cycles.
- Peak throughput: one row per STEP_RANGE+2 cycles when out_ready is held high.
- Backpressure: out_valid stays high and outputs stay unchanged for as long as out_ready=0. in_ready stays 0.
- out_ready asserted while out_valid=0 has no effect.

## Test plan
Bench uses STEP_RANGE=8, MAX_ROWS=4, MAP_WIDTH=5.

- Reset then single row: row0 = 1..8, last=1 → out_cnt=8, out_dense=1..8, out_map=0..7, out_last=1, out_valid 9 cycles after accept.
- Transitive chain, d=2 throughout:
  - row0 = 1..8 → map=0..7.
  - row1 = 3..10 → cnt=2, lanes {9,10}, map={2,3,4,5,6,7,8,9}.
  - row2 = 5..12, last=1 → map={4,5,6,7,8,9,10,11}, lanes {11,12}.
- Exception and oversize distance:
  - row1 with dist_vld=0 → cnt=8, map=8..15.
  - row1 with d=9 and dist_vld=1 → same result.
- Forced close: 5 rows with last=0 →
  - row3 has out_last=1.
  - row4 restarts the group: map=0..7, full cnt=8.
- Backpressure: out_ready=0 for 20 cycles with a row pending → outputs stable, in_ready=0. Release → exactly one handshake, then in_ready=1 on the next cycle.
- Mid-scan reset: reset at the 4th SCAN cycle of row1 → no out_valid. The next row is treated as row 0 with map starting at 0.
